// File: rtl/monedero.sv
// monedero: coin-acceptor front end -- debounced coin lines, credit accumulator, purchase arbitration.
// Define MONEDERO_CHANGE_EN to build change return (CHANGE state, gap counter, change_pulse).
module monedero_deb #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ev
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Counter saturates at DEB_CYCLES, so a held line fires once per high period.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      ev  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      ev <= s2 && (cnt == CW'(DEB_CYCLES - 1));
      if (!s2)                         cnt <= '0;
      else if (cnt != CW'(DEB_CYCLES)) cnt <= cnt + CW'(1);
    end
  end
endmodule

module monedero #(
  parameter int DEB_CYCLES = 500000,
  parameter int CREDIT_MAX = 99,
  parameter int CHANGE_GAP = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic [6:0] price,
  input  logic       buy,
  input  logic       cancel,
  output logic [6:0] credit,
  output logic       vend_ok,
  output logic       no_funds,
  output logic       reject,
  output logic       change_pulse,
  output logic       busy
);
  localparam int NUM_LANES = 3;
  localparam logic [NUM_LANES-1:0][6:0] COIN_VAL = {7'd10, 7'd5, 7'd1};
  localparam logic [7:0] CMAX = 8'(CREDIT_MAX);

  logic [NUM_LANES-1:0] raw, ev;
  logic [6:0]           coin_val, credit_nxt;
  logic [7:0]           sum;
  logic                 coin_drop, any_ev, fits;
  logic                 vend_nxt, nof_nxt, rej_nxt;

  assign raw = {coin_10, coin_5, coin_1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    monedero_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .raw(raw[i]), .ev(ev[i])
    );
  end

  // Highest-valued lane wins; any lower lane firing alongside it is dropped.
  always_comb begin
    coin_val  = '0;
    coin_drop = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if (ev[i]) begin
        coin_drop = |coin_val;
        coin_val  = COIN_VAL[i];
      end
  end

  assign any_ev = |ev;
  assign sum    = {1'b0, credit} + {1'b0, coin_val};
  assign fits   = (sum <= CMAX);

`ifdef MONEDERO_CHANGE_EN
  localparam int GW = $clog2(CHANGE_GAP);
  typedef enum logic {IDLE, CHANGE} state_t;
  state_t        state, state_nxt;
  logic [GW-1:0] gap, gap_nxt;
  logic          chg_nxt;
`else
  logic unused_cfg;
  assign unused_cfg = cancel | (CHANGE_GAP < 2);
`endif

  always_comb begin
    credit_nxt = credit;
    vend_nxt   = 1'b0;
    nof_nxt    = 1'b0;
    rej_nxt    = 1'b0;
`ifdef MONEDERO_CHANGE_EN
    state_nxt  = state;
    gap_nxt    = gap;
    chg_nxt    = 1'b0;
    if (state == CHANGE) begin
      rej_nxt = any_ev;
      if (gap == GW'(CHANGE_GAP - 1)) begin
        gap_nxt    = '0;
        chg_nxt    = 1'b1;
        credit_nxt = credit - 7'd1;
        if (credit == 7'd1) state_nxt = IDLE;
      end else begin
        gap_nxt = gap + GW'(1);
      end
    end else
`endif
    if (buy) begin
      rej_nxt = any_ev;
      if (price == 7'd0 || credit < price) begin
        nof_nxt = 1'b1;
      end else begin
        vend_nxt   = 1'b1;
        credit_nxt = credit - price;
`ifdef MONEDERO_CHANGE_EN
        if (credit != price) begin
          state_nxt = CHANGE;
          gap_nxt   = '0;
        end
`endif
      end
    end else begin
`ifdef MONEDERO_CHANGE_EN
      if (cancel && credit != 7'd0) begin
        state_nxt = CHANGE;
        gap_nxt   = '0;
      end
`endif
      if (any_ev) begin
        rej_nxt = coin_drop || !fits;
        if (fits) credit_nxt = sum[6:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit   <= '0;
      vend_ok  <= 1'b0;
      no_funds <= 1'b0;
      reject   <= 1'b0;
    end else begin
      credit   <= credit_nxt;
      vend_ok  <= vend_nxt;
      no_funds <= nof_nxt;
      reject   <= rej_nxt;
    end
  end

`ifdef MONEDERO_CHANGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gap          <= '0;
      change_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      gap          <= gap_nxt;
      change_pulse <= chg_nxt;
    end
  end
  assign busy = (state == CHANGE);
`else
  assign change_pulse = 1'b0;
  assign busy         = 1'b0;
`endif
endmodule

// File: tb/tb_monedero.sv
// Directed bench for monedero: table of single-action vectors plus hand sequences for
// debounce, change return, same-cycle priority and reset during change.
module tb_monedero;
  logic       clk = 1'b0, rst = 1'b1;
  logic       coin_1 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0;
  logic [6:0] price = '0;
  logic       buy = 1'b0, cancel = 1'b0;
  logic [6:0] credit;
  logic       vend_ok, no_funds, reject, change_pulse, busy;

  int nchk = 0, nerr = 0;

  monedero #(.DEB_CYCLES(4), .CREDIT_MAX(99), .CHANGE_GAP(3)) dut (
    .clk(clk), .rst(rst), .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .price(price), .buy(buy), .cancel(cancel), .credit(credit), .vend_ok(vend_ok),
    .no_funds(no_funds), .reject(reject), .change_pulse(change_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] coins;   // {10, 5, 1}
    logic       buy;
    logic [6:0] price;
    logic [6:0] exp_credit;
    logic       exp_rej;
    logic       exp_vend;
    logic       exp_nof;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Coin vectors: raise lines at a negedge, credit lands on the 7th edge.
  task automatic apply_vec(input int idx, input vec_t v);
    if (v.buy) begin
      price = v.price;
      buy   = 1'b1;
      @(posedge clk); @(negedge clk);
      buy = 1'b0;
    end else begin
      {coin_10, coin_5, coin_1} = v.coins;
      repeat (7) @(posedge clk);
      @(negedge clk);
    end
    chk($sformatf("v%0d credit", idx), credit, v.exp_credit);
    chk($sformatf("v%0d reject", idx), reject, v.exp_rej);
    chk($sformatf("v%0d vend_ok", idx), vend_ok, v.exp_vend);
    chk($sformatf("v%0d no_funds", idx), no_funds, v.exp_nof);
    {coin_10, coin_5, coin_1} = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, first, last, gaperr, nrej;
    bit done;

    vecs[0]  = '{3'b000, 1'b1, 7'd12, 7'd5,  1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'b000, 1'b1, 7'd0,  7'd5,  1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'b000, 1'b1, 7'd5,  7'd0,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b100, 1'b0, 7'd0,  7'd10, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 1'b0, 7'd0,  7'd20, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 1'b0, 7'd0,  7'd21, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      vecs[6+i] = '{3'b100, 1'b0, 7'd0, 7'(10*(i+1)), 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'b010, 1'b0, 7'd0,  7'd95, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{3'b100, 1'b0, 7'd0,  7'd95, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{3'b001, 1'b0, 7'd0,  7'd96, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'b000, 1'b1, 7'd96, 7'd0,  1'b0, 1'b1, 1'b0};
    vecs[19] = '{3'b101, 1'b0, 7'd0,  7'd10, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{3'b100, 1'b0, 7'd0,  7'd20, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst credit", credit, 0);
    chk("rst vend_ok", vend_ok, 0);
    chk("rst no_funds", no_funds, 0);
    chk("rst reject", reject, 0);
    chk("rst change_pulse", change_pulse, 0);
    chk("rst busy", busy, 0);

    // Debounce: 3-cycle glitch ignored; held line credited once, 7 cycles after rise
    coin_5 = 1'b1;
    repeat (3) @(negedge clk);
    coin_5 = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch credit", credit, 0);
    coin_5 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("deb early credit", credit, 0);
    @(posedge clk); @(negedge clk);
    chk("deb latency credit", credit, 5);
    repeat (13) @(negedge clk);
    coin_5 = 1'b0;
    repeat (5) @(negedge clk);
    chk("deb held once", credit, 5);

    for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

    // Vend with remainder
    price = 7'd15;
    buy   = 1'b1;
    @(posedge clk); @(negedge clk);
    buy = 1'b0;
    chk("vend15 vend_ok", vend_ok, 1);
    chk("vend15 credit", credit, 6);
`ifdef MONEDERO_CHANGE_EN
    chk("vend15 busy", busy, 1);
    n = 0; first = 0; last = 0; gaperr = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) chk("vend15 pulse width", vend_ok, 0);
      if (change_pulse) begin
        n++;
        if (n == 1) first = k;
        else if (k - last != 3) gaperr++;
        last = k;
        if (n == 6) begin
          chk("change end busy", busy, 0);
          chk("change end credit", credit, 0);
        end
      end
    end
    chk("change pulse count", n, 6);
    chk("change first pulse", first, 3);
    chk("change spacing errors", gaperr, 0);
`else
    chk("vend15 busy", busy, 0);
    n = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) chk("vend15 pulse width", vend_ok, 0);
      if (change_pulse) n++;
    end
    chk("no-change pulse count", n, 0);
    chk("no-change credit kept", credit, 6);
    apply_vec(99, '{3'b000, 1'b1, 7'd6, 7'd0, 1'b0, 1'b1, 1'b0});
`endif

    for (int i = 6; i < 21; i++) apply_vec(i, vecs[i]);

    // Priority: buy + cancel + coin event in the same IDLE cycle
    coin_5 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    price = 7'd8; buy = 1'b1; cancel = 1'b1;
    @(posedge clk); @(negedge clk);
    buy = 1'b0; cancel = 1'b0; coin_5 = 1'b0;
    chk("prio vend_ok", vend_ok, 1);
    chk("prio reject", reject, 1);
    chk("prio credit", credit, 12);
`ifdef MONEDERO_CHANGE_EN
    chk("prio busy", busy, 1);
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("prio drain done", int'(done), 1);
    chk("prio drain credit", credit, 0);
`else
    chk("prio busy", busy, 0);
    repeat (3) @(negedge clk);
    apply_vec(98, '{3'b000, 1'b1, 7'd12, 7'd0, 1'b0, 1'b1, 1'b0});
`endif
    repeat (3) @(negedge clk);

    // Build credit 7, then cancel with a coin arriving mid-change, then reset
    apply_vec(97, '{3'b010, 1'b0, 7'd0, 7'd5, 1'b0, 1'b0, 1'b0});
    apply_vec(96, '{3'b001, 1'b0, 7'd0, 7'd6, 1'b0, 1'b0, 1'b0});
    apply_vec(95, '{3'b001, 1'b0, 7'd0, 7'd7, 1'b0, 1'b0, 1'b0});
    cancel = 1'b1;
    coin_1 = 1'b1;
    n = 0; nrej = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) begin
        cancel = 1'b0;
`ifdef MONEDERO_CHANGE_EN
        chk("cancel busy", busy, 1);
`else
        chk("cancel busy", busy, 0);
`endif
      end
      if (change_pulse) n++;
      if (reject) nrej++;
    end
`ifdef MONEDERO_CHANGE_EN
    chk("cancel pulses", n, 2);
    chk("coin in change reject", nrej, 1);
    chk("cancel credit", credit, 5);
`else
    chk("cancel pulses", n, 0);
    chk("cancel coin reject", nrej, 0);
    chk("cancel credit", credit, 8);
`endif
    rst = 1'b1;
    coin_1 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("midrst credit", credit, 0);
    chk("midrst busy", busy, 0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (change_pulse) n++;
    end
    chk("midrst no pulses", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
